// File: rtl/uart_loader_if.sv
// Byte-stream input from uart_rx and single-port memory write bus for uart_loader.
// The master side is the loader; the slave side feeds bytes and observes writes.
interface uart_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_we;

    modport master (
        input  rx_data,
        input  rx_ready,
        output mem_addr,
        output mem_data,
        output mem_we
    );

    modport slave (
        output rx_data,
        output rx_ready,
        input  mem_addr,
        input  mem_data,
        input  mem_we
    );
endinterface

// File: rtl/uart_loader.sv
// Serial image loader: frames of LEN_LO LEN_HI {D_LO D_HI}xN CSUM from uart_rx are
// written as 16-bit words to memory starting at BASE_ADDR.
module uart_loader #(
    parameter int ADDR_W       = 16,
    parameter int BASE_ADDR    = 0,
    parameter int MAX_WORDS    = 4096,
    parameter int TIMEOUT_CLKS = 200000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    uart_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        D_LO   = 3'd3,
        D_HI   = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam int                TW         = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [16:0]       MAX_LEN    = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    state_t            state_reg, state_next;
    logic              rx_ready_q_reg;
    logic [15:0]       len_reg, len_next;
    logic [15:0]       count_reg, count_next;
    logic [7:0]        csum_reg, csum_next;
    logic [7:0]        low_reg, low_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [15:0]       data_reg, data_next;
    logic              we_reg, we_next;
    logic              done_reg, done_next;
    logic              error_reg, error_next;

    logic ev;
    logic in_frame;
    logic start;
    logic timeout;
    logic last_word;
    logic len_bad;
    logic len_zero;

    // One event per rising edge of the uart_rx ready level.
    assign ev        = bus.rx_ready & ~rx_ready_q_reg;
    assign in_frame  = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERR);
    assign start     = ev && enable && !in_frame;
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign timeout   = in_frame && !ev && (timer_reg == TIMER_LAST);
    assign last_word = ((count_reg + 16'd1) == len_reg);
    assign len_bad   = ({1'b0, len_reg} > MAX_LEN);
    assign len_zero  = (len_reg == 16'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (ev)           state_next = LEN_HI;
                else if (timeout) state_next = ERR;
            end
            LEN_HI: begin
                if (len_bad)       state_next = ERR;
                else if (len_zero) state_next = CSUM;
                else               state_next = D_LO;
            end
            D_LO: begin
                if (ev)           state_next = D_HI;
                else if (timeout) state_next = ERR;
            end
            D_HI: begin
                if (ev)           state_next = last_word ? CSUM : D_LO;
                else if (timeout) state_next = ERR;
            end
            CSUM: begin
                if (ev)           state_next = (bus.rx_data == csum_reg) ? DONE : ERR;
                else if (timeout) state_next = ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        len_next   = len_reg;
        count_next = count_reg;
        csum_next  = csum_reg;
        low_next   = low_reg;
        data_next  = data_reg;
        we_next    = 1'b0;
        done_next  = done_reg;
        error_next = error_reg;
        timer_next = (ev || !in_frame) ? '0 : timer_reg + TW'(1);
        // The address advances in the cycle after the write strobe.
        addr_next  = we_reg ? addr_reg + ADDR_W'(1) : addr_reg;
        busy       = in_frame;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    done_next  = 1'b0;
                    error_next = 1'b0;
                    csum_next  = 8'd0;
                    count_next = 16'd0;
                    addr_next  = BASE;
                    len_next   = {8'h00, bus.rx_data};
                end
            end
            LEN_LO: begin
                if (ev) len_next = {bus.rx_data, len_reg[7:0]};
            end
            D_LO: begin
                if (ev) begin
                    low_next  = bus.rx_data;
                    csum_next = csum_reg + bus.rx_data;
                end
            end
            D_HI: begin
                if (ev) begin
                    data_next  = {bus.rx_data, low_reg};
                    we_next    = 1'b1;
                    csum_next  = csum_reg + bus.rx_data;
                    count_next = count_reg + 16'd1;
                end
            end
            default: ;
        endcase

        if (state_next == DONE && state_reg != DONE) done_next  = 1'b1;
        if (state_next == ERR  && state_reg != ERR)  error_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_q_reg <= 1'b0;
            len_reg        <= 16'd0;
            count_reg      <= 16'd0;
            csum_reg       <= 8'd0;
            low_reg        <= 8'd0;
            timer_reg      <= '0;
            addr_reg       <= BASE;
            data_reg       <= 16'd0;
            we_reg         <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            rx_ready_q_reg <= bus.rx_ready;
            len_reg        <= len_next;
            count_reg      <= count_next;
            csum_reg       <= csum_next;
            low_reg        <= low_next;
            timer_reg      <= timer_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            we_reg         <= we_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

    assign bus.mem_addr = addr_reg;
    assign bus.mem_data = data_reg;
    assign bus.mem_we   = we_reg;
    assign done         = done_reg;
    assign error        = error_reg;
endmodule
